// File: rtl/led_scan_driver_if.sv
// Pixel frames, run request and row/column drive outputs of the LED scan driver.
interface led_scan_driver_if;
  logic            enable;
  logic [7:0][7:0] red_pixels;
  logic [7:0][7:0] grn_pixels;
  logic [7:0]      row_sink;
  logic [7:0]      red;
  logic [7:0]      green;
  logic            frame_done;
  logic [7:0]      frame_count;

  modport master (
    output enable, red_pixels, grn_pixels,
    input  row_sink, red, green, frame_done, frame_count
  );

  modport slave (
    input  enable, red_pixels, grn_pixels,
    output row_sink, red, green, frame_done, frame_count
  );
endinterface

// File: rtl/led_scan_driver.sv
// 8x8 bi-colour LED matrix scanner: per frame, latch a shadow copy of the pixels,
// then for each row emit BLANK dark cycles followed by DWELL cycles of drive.
module led_scan_driver #(
  parameter int unsigned DWELL = 16,
  parameter int unsigned BLANK = 2
) (
  input logic              clk,
  input logic              reset,
  led_scan_driver_if.slave bus
);
  localparam int unsigned CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BLANK, ST_DRIVE} state_t;

  state_t          state;
  logic [2:0]      row;
  logic [CW-1:0]   cnt;
  logic [7:0][7:0] shadow_red;
  logic [7:0][7:0] shadow_grn;

  // Outputs are registered alongside the state, set up on the edge entering each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      row             <= '0;
      cnt             <= '0;
      shadow_red      <= '0;
      shadow_grn      <= '0;
      bus.row_sink    <= '1;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.frame_done  <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shadow_red <= bus.red_pixels;
          shadow_grn <= bus.grn_pixels;
          row        <= '0;
          cnt        <= '0;
          state      <= ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt == CW'(BLANK - 1)) begin
            cnt          <= '0;
            state        <= ST_DRIVE;
            bus.row_sink <= ~(8'd1 << row);
            bus.red      <= shadow_red[row];
            bus.green    <= shadow_grn[row];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == CW'(DWELL - 1)) begin
            cnt          <= '0;
            bus.row_sink <= '1;
            bus.red      <= '0;
            bus.green    <= '0;
            if (row == 3'd7) begin
              row             <= '0;
              bus.frame_done  <= 1'b1;
              bus.frame_count <= bus.frame_count + 8'd1;
              state           <= bus.enable ? ST_LOAD : ST_IDLE;
            end else begin
              row   <= row + 3'd1;
              state <= ST_BLANK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 Parameter DWELL, default 16, SHALL be the number of clk cycles each row is driven (legal range 1..255).
REQ-002 Parameter BLANK, default 2, SHALL be the number of all-off clk cycles before each row (legal range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 enable  input  1  SHALL be the scan-run request; high starts and continues frames.
REQ-006 red_pixels  input  [7:0][7:0]  SHALL be the red frame, indexed [row][col], 1 = lit.
REQ-007 grn_pixels  input  [7:0][7:0]  SHALL be the green frame, indexed [row][col], 1 = lit.
REQ-008 row_sink  output  8  SHALL be active-low row select; at most one bit low at any time.
REQ-009 red  output  8  SHALL be active-high red column drive for the selected row.
REQ-010 green  output  8  SHALL be active-high green column drive for the selected row.
REQ-011 frame_done  output  1  SHALL be a one-cycle pulse at the end of each complete frame.
REQ-012 frame_count  output  8  SHALL count completed frames, wrapping 255 -> 0.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, BLANK, DRIVE.
REQ-014 All outputs SHALL be decoded from registered state only; no combinational path from any input to any output.
REQ-015 IDLE: row_sink=8'hFF, red=0, green=0; enable=1 -> LOAD next cycle, else stay in IDLE.
REQ-016 LOAD lasts exactly 1 cycle: shadow_red/shadow_grn SHALL capture red_pixels/grn_pixels at the edge leaving LOAD; row index set to 0; next state BLANK.
REQ-017 BLANK lasts exactly BLANK cycles with row_sink=8'hFF, red=0, green=0; next state DRIVE.
REQ-018 DRIVE lasts exactly DWELL cycles with row_sink[r]=0, other row_sink bits =1, red=shadow_red[r], green=shadow_grn[r].
REQ-019 Leaving DRIVE with r<7: r increments, next state BLANK.
REQ-020 Leaving DRIVE with r=7: frame_done=1 for the following single cycle, frame_count increments, r=0; next state LOAD if enable=1, else IDLE.
REQ-021 Frame period with enable held high SHALL be 1 + 8*(BLANK+DWELL) cycles (145 at defaults).
REQ-022 Input pixel changes after LOAD SHALL have no effect until the next LOAD (no tearing).
REQ-023 enable deasserted mid-frame SHALL NOT abort the frame; the scan completes row 7 and then enters IDLE.
REQ-024 A pixel set in both shadow_red and shadow_grn SHALL drive both red and green (yellow); no priority.
REQ-025 Dwell and blank counters SHALL be wide enough for their parameters and SHALL reset to 0 on every state entry.

Reset
REQ-026 reset=1 SHALL force, on the next edge: state=IDLE, r=0, counters=0, shadow_red=0, shadow_grn=0, frame_count=0.
REQ-027 During and after reset, outputs SHALL be row_sink=8'hFF, red=0, green=0, frame_done=0.
REQ-028 reset asserted mid-frame SHALL override every state, including a pending frame_done, with no partial pulse.

Verification
REQ-029 Reset, enable=0 for 20 cycles -> row_sink=8'hFF, red=0, green=0, frame_done=0 throughout.
REQ-030 enable=1, red_pixels[r]=8'h01<<r, grn_pixels=0 -> row r low for exactly 16 cycles, red=8'h01<<r, each row preceded by 2 blank cycles; frame_done pulses at cycle 145, frame_count=1.
REQ-031 After LOAD, change red_pixels to all 8'hFF mid-frame -> current frame unchanged; next frame shows 8'hFF on every row.
REQ-032 red_pixels[3]=grn_pixels[3]=8'hA5 -> during row-3 DRIVE, red=green=8'hA5 simultaneously.
REQ-033 Drop enable during row 4 -> rows 4..7 complete, one frame_done pulse, then IDLE with outputs off; reassert -> LOAD the next cycle.
REQ-034 Assert reset during row 7 DRIVE, then run 256 frames -> no frame_done on reset, frame_count wraps 255 -> 0, row_sink never has more than one low bit.
